// File: rtl/dual_edge_generator_if.sv
// Bundles the request input and the waveform/status outputs of the dual edge generator.
// The master drives req; the slave (the generator) drives everything else.
interface dual_edge_generator_if #(
    parameter int CNT_W = 3
);
    logic             req;
    logic             level;
    logic             edge_done;
    logic             busy;
    logic [CNT_W-1:0] pend_cnt;
    logic             overflow;

    modport master (
        output req,
        input  level,
        input  edge_done,
        input  busy,
        input  pend_cnt,
        input  overflow
    );

    modport slave (
        input  req,
        output level,
        output edge_done,
        output busy,
        output pend_cnt,
        output overflow
    );
endinterface

// File: rtl/dual_edge_generator.sv
// Turns one-cycle toggle requests into level edges spaced at least 1+HOLD_CYCLES cycles apart.
// Requests that arrive during the spacing are queued in a saturating pending counter.
module dual_edge_generator #(
    parameter int HOLD_CYCLES = 4,
    parameter int CNT_W       = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    dual_edge_generator_if.slave bus
);
    localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [HW-1:0]    HOLD_LOAD = HW'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] PEND_MAX  = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        IDLE,
        EDGE,
        HOLD
    } state_t;

    state_t           state;
    state_t           next_state;
    logic [HW-1:0]    hold_cnt;
    logic [CNT_W-1:0] pend_q;
    logic             level_q;
    logic             overflow_q;
    logic             edge_done_c;
    logic             busy_c;
    logic             enter_edge;
    logic             drop;
    logic             accept;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (pend_q != '0) begin
                    next_state = EDGE;
                end
            end
            EDGE: begin
                next_state = HOLD;
            end
            HOLD: begin
                if (hold_cnt == '0) begin
                    next_state = (pend_q != '0) ? EDGE : IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // A request arriving on the same edge that consumes one still fits when the counter is full.
    assign enter_edge = (next_state == EDGE);
    assign drop       = bus.req && (pend_q == PEND_MAX) && !enter_edge;
    assign accept     = bus.req && !drop;

    always_ff @(posedge clk) begin
        if (reset) begin
            hold_cnt   <= '0;
            pend_q     <= '0;
            level_q    <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            if (state == EDGE) begin
                hold_cnt <= HOLD_LOAD;
            end else if (state == HOLD && hold_cnt != '0) begin
                hold_cnt <= hold_cnt - 1'b1;
            end

            if (enter_edge) begin
                level_q <= ~level_q;
            end

            case ({accept, enter_edge})
                2'b10:   pend_q <= pend_q + 1'b1;
                2'b01:   pend_q <= pend_q - 1'b1;
                default: pend_q <= pend_q;
            endcase

            if (drop) begin
                overflow_q <= 1'b1;
            end
        end
    end

    always_comb begin
        edge_done_c = (state == EDGE);
        busy_c      = (state != IDLE) || (pend_q != '0);
    end

    assign bus.level     = level_q;
    assign bus.edge_done = edge_done_c;
    assign bus.busy      = busy_c;
    assign bus.pend_cnt  = pend_q;
    assign bus.overflow  = overflow_q;
endmodule

// File: doc/dual_edge_generator.md
DUAL_EDGE_GENERATOR -- requirements
Module: dual_edge_generator

Interface
REQ-001 Parameter HOLD_CYCLES, default 4, meaning cycles the level SHALL stay stable after each toggle; legal range 1..255.
REQ-002 Parameter CNT_W, default 3, meaning width of the pending-request counter; legal range 1..8.
REQ-003 clk  input  1  meaning single clock; all state SHALL update on its rising edge.
REQ-004 reset  input  1  meaning synchronous, active-high reset.
REQ-005 req  input  1  meaning one-cycle toggle request, sampled every rising edge; a multi-cycle high counts as one request per cycle.
REQ-006 level  output  1  meaning generated waveform; registered; each accepted request produces exactly one edge, rising or falling.
REQ-007 edge_done  output  1  meaning Moore output, high for exactly the one cycle the FSM is in EDGE.
REQ-008 busy  output  1  meaning high when state is not IDLE or pend_cnt is nonzero.
REQ-009 pend_cnt  output  CNT_W  meaning requests accepted but not yet emitted.
REQ-010 overflow  output  1  meaning sticky flag: a request was dropped.

Function
REQ-011 The FSM SHALL have the states IDLE, EDGE and HOLD, with all outputs decoded from registers only.
REQ-012 IDLE SHALL go to EDGE when pend_cnt is nonzero at the clock edge; otherwise it SHALL stay in IDLE.
REQ-013 On the clock edge entering EDGE, the block SHALL invert level and decrement pend_cnt by 1.
REQ-014 EDGE SHALL last one cycle, then go to HOLD with the hold counter loaded to HOLD_CYCLES-1.
REQ-015 HOLD SHALL decrement the hold counter each cycle; when the counter is 0 the FSM SHALL leave HOLD.
REQ-016 On leaving HOLD, the FSM SHALL go directly to EDGE if pend_cnt is nonzero, else to IDLE.
REQ-017 The minimum spacing between successive level toggles SHALL therefore be 1+HOLD_CYCLES cycles.
REQ-018 Latency: a req sampled high at edge k with the FSM in IDLE and pend_cnt 0 SHALL give pend_cnt=1 after edge k and a level toggle at edge k+1.
REQ-018a Under the REQ-018 conditions, edge_done SHALL be high from edge k+1 to edge k+2.
REQ-019 pend_cnt update rules, per clock edge:
- increment alone: +1;
- decrement alone: -1;
- simultaneous increment and decrement: net unchanged, and the request is accepted.
REQ-020 Saturation: when pend_cnt = 2^CNT_W-1, req is high and no decrement occurs, the request SHALL be dropped, pend_cnt SHALL hold, and overflow SHALL set.
REQ-021 overflow SHALL stay set until reset.
REQ-022 req SHALL be ignored during reset.
REQ-023 The hold counter SHALL be wide enough for HOLD_CYCLES-1 and SHALL never wrap.

Reset
REQ-024 While reset is high at a clock edge, the next state SHALL be:
- state=IDLE, hold counter=0;
- level=0, edge_done=0, busy=0, pend_cnt=0, overflow=0.
REQ-025 Reset asserted mid-operation (EDGE or HOLD, pend_cnt nonzero) SHALL discard all pending requests.
REQ-026 After such a reset, level SHALL be 0 on the next edge, regardless of its prior value.
REQ-027 After reset deasserts, the block SHALL be ready to accept req on the first edge.

Verification
REQ-028 Single request: HOLD_CYCLES=4; reset, then req=1 for one cycle at edge k -> pend_cnt=1 after k; level 0->1 at k+1; edge_done=1 during cycle k+1..k+2; busy=0 from edge k+6.
REQ-029 Burst of 3: req high 3 cycles from edge k -> level toggles at k+1, k+6, k+11; final level=1; edge_done pulses exactly 3 times; pend_cnt reaches 0 at edge k+11.
REQ-030 Overflow: CNT_W=3, HOLD_CYCLES=4; req held high 12 cycles -> pend_cnt saturates at 7; overflow=1 on the first dropped request and stays 1; level toggles equal accepted requests.
REQ-031 Simultaneous: req high on the edge that enters EDGE with pend_cnt=1 -> pend_cnt stays 1, and a second toggle follows 5 cycles later.
REQ-032 Reset mid-HOLD: pend_cnt=3, level=1, reset for 1 cycle -> after that edge, level=0, pend_cnt=0, busy=0, edge_done=0, and no further toggles occur without new req.
REQ-033 Loopback: level feeds the team's dual edge detector -> one detector tick per accepted req, and no missed or extra ticks over 20 random req patterns.
